// File: rtl/seg7_pkg.sv
// Purpose : shared pattern constants, decode helper and FSM state type for the
//           7-segment pattern decoder (active-low segments, bit6=g .. bit0=a).
// Ports   : none (package).
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // legal = pattern is one of the 16 digit codes; blank is reported separately
  // so it is neither a digit nor an error.
  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] nibble;
  } seg7_dec_t;

  typedef enum logic {HUNT, EMIT} seg7_dec_state_t;

  function automatic seg7_dec_t seg7_decode(input logic [6:0] seg);
    seg7_dec_t d;
    d = '0;
    d.legal = 1'b1;
    case (seg)
      SEG_0:     d.nibble = 4'h0;
      SEG_1:     d.nibble = 4'h1;
      SEG_2:     d.nibble = 4'h2;
      SEG_3:     d.nibble = 4'h3;
      SEG_4:     d.nibble = 4'h4;
      SEG_5:     d.nibble = 4'h5;
      SEG_6:     d.nibble = 4'h6;
      SEG_7:     d.nibble = 4'h7;
      SEG_8:     d.nibble = 4'h8;
      SEG_9:     d.nibble = 4'h9;
      SEG_A:     d.nibble = 4'hA;
      SEG_B:     d.nibble = 4'hB;
      SEG_C:     d.nibble = 4'hC;
      SEG_D:     d.nibble = 4'hD;
      SEG_E:     d.nibble = 4'hE;
      SEG_F:     d.nibble = 4'hF;
      SEG_BLANK: begin
        d.legal = 1'b0;
        d.blank = 1'b1;
      end
      default:   d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg7_stability_filter.sv
// Purpose : debounce a 7-bit segment bus; pulse once when a pattern has been seen
//           on STABLE_CYCLES consecutive enabled samples.
// Latency : stable_hit/stable_seg registered on the edge taking the final sample.
// Backpressure: none; runs every cycle, sample_en=0 cycles freeze the run.
// Ports   : clk, reset (async high), seg_in[6:0], sample_en -> stable_seg[6:0], stable_hit
module seg7_stability_filter #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg_in,
  input  logic       sample_en,
  output logic [6:0] stable_seg,
  output logic       stable_hit
);
  import seg7_pkg::*;

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [6:0]    last_seg;
  logic [CW-1:0] stab_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_seg   <= SEG_BLANK;
      stab_cnt   <= '0;
      stable_hit <= 1'b0;
    end else begin
      stable_hit <= 1'b0;
      if (sample_en) begin
        if (seg_in == last_seg) begin
          // Saturating count: once at the limit the run has already hit,
          // so a held pattern yields exactly one pulse.
          if (stab_cnt != CNT_MAX) begin
            stab_cnt   <= stab_cnt + CNT_ONE;
            stable_hit <= (stab_cnt + CNT_ONE) == CNT_MAX;
          end
        end else begin
          last_seg   <= seg_in;
          stab_cnt   <= CNT_ONE;
          stable_hit <= (CNT_ONE == CNT_MAX);
        end
      end
    end
  end

  // The pattern that produced the hit is the one now held in last_seg.
  assign stable_seg = last_seg;

endmodule

// File: rtl/seg7_pattern_decoder.sv
// Purpose : decode a debounced active-low 7-seg bus back to a hex digit with valid/ready out.
// Latency : out_valid rises 1 clk after the edge of the sample completing a stable run.
// Backpressure: one-deep; digits stabilising while out_valid=1 are dropped and set overrun.
// Ports   : clk, reset (async high), seg_in[6:0], sample_en, out_ready ->
//           out_valid, out_nibble[3:0], err_pulse, err_count[ERR_W-1:0], overrun
module seg7_pattern_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       seg_in,
  input  logic             sample_en,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [3:0]       out_nibble,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             overrun
);
  import seg7_pkg::*;

  logic [6:0] stable_seg;
  logic       stable_hit;

  seg7_stability_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk       (clk),
    .reset     (reset),
    .seg_in    (seg_in),
    .sample_en (sample_en),
    .stable_seg(stable_seg),
    .stable_hit(stable_hit)
  );

  seg7_dec_state_t state_q, state_d;
  seg7_dec_t       dec;
  logic [3:0]      nibble_d;
  logic            err_pulse_d;
  logic [ERR_W-1:0] err_count_d;
  logic            overrun_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= HUNT;
      out_nibble <= 4'h0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
      overrun    <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_nibble <= nibble_d;
      err_pulse  <= err_pulse_d;
      err_count  <= err_count_d;
      overrun    <= overrun_d;
    end
  end

  always_comb begin
    dec         = seg7_decode(stable_seg);
    state_d     = state_q;
    nibble_d    = out_nibble;
    err_pulse_d = 1'b0;
    err_count_d = err_count;
    overrun_d   = overrun;

    // Invalid patterns are counted in either state.
    if (stable_hit && !dec.legal && !dec.blank) begin
      err_pulse_d = 1'b1;
      if (err_count != {ERR_W{1'b1}})
        err_count_d = err_count + 1'b1;
    end

    case (state_q)
      HUNT: begin
        if (stable_hit && dec.legal) begin
          nibble_d = dec.nibble;
          state_d  = EMIT;
        end
      end
      EMIT: begin
        // A digit arriving in the handover cycle is dropped too: no reload.
        if (stable_hit && dec.legal)
          overrun_d = 1'b1;
        if (out_ready)
          state_d = HUNT;
      end
      default: state_d = HUNT;
    endcase
  end

  // Derived from the async-reset state register so reset clears it immediately.
  assign out_valid = (state_q == EMIT);

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// Purpose : self-checking bench for seg7_pattern_decoder; scoreboard of expected
//           digits popped on each accepted output, plus per-scenario inline checks.
// Ports   : none (top-level bench).
module tb_seg7_pattern_decoder;

  logic       clk;
  logic       reset;
  logic [6:0] seg_in;
  logic       sample_en;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_nibble;
  logic       err_pulse;
  logic [7:0] err_count;
  logic       overrun;

  int checks;
  int errors;
  logic [3:0] sb[$];
  int exp_err;

  localparam logic [6:0] BLANK = 7'b1111111;
  logic [6:0] codes [16];

  seg7_pattern_decoder #(
    .STABLE_CYCLES(4),
    .ERR_W(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .seg_in    (seg_in),
    .sample_en (sample_en),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_nibble(out_nibble),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every accepted output must match the oldest expected digit.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got nibble %h, expected no output", out_nibble);
      end else begin
        logic [3:0] exp;
        exp = sb.pop_front();
        if (out_nibble !== exp) begin
          errors++;
          $display("FAIL output_digit: got %h, expected %h", out_nibble, exp);
        end
      end
    end
  end

  task automatic sample(input logic [6:0] s);
    seg_in    = s;
    sample_en = 1'b1;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
  endtask

  task automatic idle(input int n);
    sample_en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #3;
    checks++;
    if ({out_valid, out_nibble, err_pulse, err_count, overrun} !== 15'd0) begin
      errors++;
      $display("FAIL reset_state: got v=%b n=%h e=%b c=%0d o=%b, expected all zero",
               out_valid, out_nibble, err_pulse, err_count, overrun);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_all_codes;
    out_ready = 1'b1;
    for (int d = 0; d < 16; d++) begin
      sb.push_back(4'(d));
      repeat (4) sample(codes[d]);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL early_valid digit %0d: got %b, expected 0", d, out_valid);
      end
      sample(BLANK);
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL latency_valid digit %0d: got %b, expected 1", d, out_valid);
      end
      sample(BLANK);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL valid_one_cycle digit %0d: got %b, expected 0", d, out_valid);
      end
    end
    idle(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL all_codes_pending: got %0d undelivered, expected 0", sb.size());
    end
  endtask

  task automatic test_long_hold;
    sb.push_back(4'h6);
    repeat (20) sample(7'b0000010);
    repeat (2) sample(BLANK);
    idle(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL long_hold_pending: got %0d undelivered, expected 0", sb.size());
    end
  endtask

  task automatic test_glitch;
    sb.push_back(4'h3);
    repeat (3) sample(7'b1111001);
    repeat (5) sample(7'b0110000);
    repeat (2) sample(BLANK);
    idle(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL glitch_pending: got %0d undelivered, expected 0", sb.size());
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: got %b, expected 0", overrun);
    end
  endtask

  task automatic test_invalid;
    repeat (4) sample(7'b1010101);
    checks++;
    if (err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse_early: got %b, expected 0", err_pulse);
    end
    sample(BLANK);
    exp_err = 1;
    checks++;
    if (err_pulse !== 1'b1 || err_count !== 8'(exp_err) || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL invalid_detect: got pulse=%b count=%0d valid=%b, expected 1 %0d 0",
               err_pulse, err_count, out_valid, exp_err);
    end
    sample(BLANK);
    checks++;
    if (err_pulse !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse_width: got %b, expected 0", err_pulse);
    end
    for (int r = 1; r < 300; r++) begin
      repeat (4) sample(7'b1010101);
      sample(BLANK);
      if (exp_err < 255) exp_err++;
    end
    idle(2);
    checks++;
    if (err_count !== 8'(exp_err)) begin
      errors++;
      $display("FAIL err_saturate: got %0d, expected %0d", err_count, exp_err);
    end
  endtask

  task automatic test_overrun;
    out_ready = 1'b0;
    sb.push_back(4'hA);
    repeat (4) sample(7'b0001000);
    repeat (4) sample(BLANK);
    repeat (4) sample(7'b0001110);
    repeat (2) sample(BLANK);
    checks++;
    if (out_valid !== 1'b1 || out_nibble !== 4'hA || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_hold: got v=%b n=%h o=%b, expected 1 a 1",
               out_valid, out_nibble, overrun);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL overrun_release: got %b, expected 0", out_valid);
    end
    idle(4);
    checks++;
    if (sb.size() != 0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_after: got pending=%0d overrun=%b, expected 0 1",
               sb.size(), overrun);
    end
  endtask

  task automatic test_reset_in_emit;
    out_ready = 1'b0;
    repeat (5) sample(7'b0000000);
    checks++;
    if (out_valid !== 1'b1 || out_nibble !== 4'h8) begin
      errors++;
      $display("FAIL emit_entry: got v=%b n=%h, expected 1 8", out_valid, out_nibble);
    end
    #2;
    reset = 1'b1;
    #1;
    exp_err = 0;
    checks++;
    if (out_valid !== 1'b0 || err_count !== 8'(exp_err) || overrun !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got v=%b c=%0d o=%b, expected 0 0 0",
               out_valid, err_count, overrun);
    end
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (2) sample(7'b0011001);
    idle(6);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL short_run: got %b, expected 0", out_valid);
    end
    // Idle cycles neither advance nor break the run: two more samples complete it.
    sb.push_back(4'h4);
    repeat (2) sample(7'b0011001);
    repeat (2) sample(BLANK);
    idle(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL resume_run: got %0d undelivered, expected 0", sb.size());
    end
  endtask

  initial begin
    clk       = 1'b0;
    reset     = 1'b1;
    seg_in    = BLANK;
    sample_en = 1'b0;
    out_ready = 1'b0;
    checks    = 0;
    errors    = 0;
    exp_err   = 0;
    codes = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    test_reset();
    test_all_codes();
    test_long_hold();
    test_glitch();
    test_invalid();
    test_overrun();
    test_reset_in_emit();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
